// File: rtl/align_shifter_seq.sv
// Multi-cycle mantissa alignment/normalisation shifter.
// Shifts up to STEP positions per clock and tracks guard, round and sticky.
module align_shifter_seq #(
    parameter int W    = 23,
    parameter int SW   = 8,
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  num,
    input  logic [SW-1:0] shiftQtt,
    input  logic          dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          guard,
    output logic          round_bit,
    output logic          sticky
);

    localparam int RW = $clog2(W + 3);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_n;
    logic [W+1:0]  work;
    logic [W+1:0]  work_n;
    logic          stk;
    logic          stk_n;
    logic          dir_r;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_n;
    logic [RW-1:0] k;
    logic [RW-1:0] e;
    logic [31:0]   sq;
    logic          take;

    assign sq   = 32'(shiftQtt);
    assign take = in_valid && in_ready;

    // Clamp the requested shift to the point where everything has left the register
    always_comb begin
        e = RW'(sq);
        if (dir) begin
            if (sq > 32'(W)) e = RW'(W);
        end else begin
            if (sq > 32'(W + 2)) e = RW'(W + 2);
        end
    end

    assign k     = (rem > RW'(STEP)) ? RW'(STEP) : rem;
    assign rem_n = rem - k;

    // One shift step; right shifts fold the departing bits into sticky
    always_comb begin
        work_n = work;
        stk_n  = stk;
        if (dir_r) begin
            work_n = work << k;
        end else begin
            work_n = work >> k;
            for (int i = 0; i < STEP; i++) begin
                if (RW'(i) < k) stk_n = stk_n | work[i];
            end
        end
    end

    // State register; reset aborts any in-flight transaction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = SHIFT;
            end
            SHIFT: begin
                if (rem_n == '0) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Working register, sticky flag and remaining count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            stk   <= 1'b0;
            rem   <= '0;
            dir_r <= 1'b0;
        end else if (take) begin
            work  <= {num, 2'b00};
            stk   <= 1'b0;
            rem   <= e;
            dir_r <= dir;
        end else if (state == SHIFT) begin
            work <= work_n;
            stk  <= stk_n;
            rem  <= rem_n;
        end
    end

    // Results are only exposed while a finished value is being offered
    always_comb begin
        result    = '0;
        guard     = 1'b0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        if (state == DONE) begin
            result    = work[W+1:2];
            guard     = work[1];
            round_bit = work[0];
            sticky    = stk;
        end
    end

endmodule

// File: tb/tb_align_shifter_seq.sv
// Directed self-checking bench for align_shifter_seq (W=23, SW=8, STEP=4).
// Latency counts the rising edge at which out_valid is first seen high, accept edge excluded.
module tb_align_shifter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] num;
    logic [7:0]  shiftQtt;
    logic        dir;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] result;
    logic        guard;
    logic        round_bit;
    logic        sticky;

    int vectors = 0;
    int miscompares = 0;

    align_shifter_seq #(.W(23), .SW(8), .STEP(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .num(num),
        .shiftQtt(shiftQtt),
        .dir(dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .guard(guard),
        .round_bit(round_bit),
        .sticky(sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one request, wait for the result, check it, then consume it.
    task automatic run(input string tag, input logic [22:0] n, input logic [7:0] s,
                       input logic d, input logic [22:0] er, input logic eg,
                       input logic erb, input logic es, input int elat);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        num      = n;
        shiftQtt = s;
        dir      = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_grs"}, {29'd0, guard, round_bit, sticky}, {29'd0, eg, erb, es});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        shiftQtt  = '0;
        dir       = 1'b0;
        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", {6'd0, result, guard, round_bit, sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("r6",    23'h700000, 8'd6,   1'b0, 23'h01C000, 0, 0, 0, 3);
        run("r2",    23'h00000F, 8'd2,   1'b0, 23'h000003, 1, 1, 0, 2);
        run("r5",    23'h00000F, 8'd5,   1'b0, 23'h000000, 0, 1, 1, 3);
        run("r0",    23'h00000F, 8'd0,   1'b0, 23'h00000F, 0, 0, 0, 2);
        run("r200",  23'h400001, 8'd200, 1'b0, 23'h000000, 0, 0, 1, 8);
        run("r4",    23'h0000F3, 8'd4,   1'b0, 23'h00000F, 0, 0, 1, 2);
        run("r8",    23'h000180, 8'd8,   1'b0, 23'h000001, 1, 0, 0, 3);
        run("l21",   23'h00000F, 8'd21,  1'b1, 23'h600000, 0, 0, 0, 7);
        run("l30",   23'h00000F, 8'd30,  1'b1, 23'h000000, 0, 0, 0, 7);
        run("l23",   23'h7FFFFF, 8'd23,  1'b1, 23'h000000, 0, 0, 0, 7);
        run("l3",    23'h400005, 8'd3,   1'b1, 23'h000028, 0, 0, 0, 2);

        // Back-pressure: hold result for 5 clocks while a stray request is offered
        @(negedge clk);
        in_valid = 1'b1;
        num      = 23'h00000F;
        shiftQtt = 8'd2;
        dir      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        num      = 23'h123456;
        shiftQtt = 8'd1;
        dir      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_out", {6'd0, result, guard, round_bit, sticky}, {6'd0, 23'h000003, 3'b110});
            chk("stall_hs", {30'd0, in_ready, out_valid}, 32'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_drop", {30'd0, in_ready, out_valid}, 32'b10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_noacc", {30'd0, in_ready, out_valid}, 32'b10);

        // Asynchronous reset in the middle of a long right shift
        in_valid = 1'b1;
        num      = 23'h7FFFFF;
        shiftQtt = 8'd25;
        dir      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hs", {30'd0, in_ready, out_valid}, 32'b10);
        chk("arst_out", {6'd0, result, guard, round_bit, sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post", 23'h700000, 8'd6, 1'b0, 23'h01C000, 0, 0, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/align_shifter_seq.md
ALIGN_SHIFTER_SEQ -- requirements
Module: align_shifter_seq

Interface
REQ-001 SHALL have parameter W, default 23, mantissa width in bits.
REQ-002 SHALL have parameter SW, default 8, shift-amount width in bits.
REQ-003 SHALL have parameter STEP, default 4, maximum bit positions shifted per clock, legal range 1..W.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 SHALL have port num, input, W, mantissa operand.
REQ-009 SHALL have port shiftQtt, input, SW, unsigned shift amount.
REQ-010 SHALL have port dir, input, 1, direction: 0 = right (alignment), 1 = left (normalisation).
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port result, output, W, shifted mantissa.
REQ-014 SHALL have port guard, output, 1, first bit below result LSB.
REQ-015 SHALL have port round_bit, output, 1, second bit below result LSB.
REQ-016 SHALL have port sticky, output, 1, OR of all bits shifted below round_bit.

Function
REQ-017 SHALL implement the FSM states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 SHALL accept a request on a rising edge where in_valid && in_ready, capturing num, dir and the effective shift E into internal state, and SHALL move IDLE->SHIFT.
REQ-019 SHALL compute E as min(shiftQtt, W+2) for right shifts and min(shiftQtt, W) for left shifts.
REQ-020 SHALL use a working register of W+2 bits {mantissa, G, R}, initialised to {num, 0, 0}, plus a sticky flag initialised to 0.
REQ-021 SHALL, on each SHIFT cycle, shift by k = min(remaining, STEP) and decrement remaining by k.
- Right shift: zeros enter at the MSB; bits leaving the R position are ORed into sticky.
- Left shift: zeros enter at the G/R end; bits leaving the MSB are discarded; guard, round_bit and sticky stay 0.
REQ-022 SHALL transition SHIFT->DONE on the cycle where remaining becomes 0.
- The number of SHIFT cycles is N = max(1, ceil(E/STEP)).
- E = 0 spends exactly one SHIFT cycle with k = 0.
- out_valid SHALL rise N+1 clocks after the accepting edge.
REQ-023 SHALL drive result, guard, round_bit and sticky from the working register in DONE.
- These outputs SHALL remain stable while out_valid && !out_ready.
REQ-024 SHALL transition DONE->IDLE on a rising edge where out_valid && out_ready.
- A new request SHALL be accepted no earlier than the following edge; requests do not overlap.
REQ-025 SHALL ignore in_valid, num, shiftQtt and dir outside IDLE.
REQ-026 SHALL produce a result of 0, guard/round_bit 0 and sticky = |num when a right shift has shiftQtt >= W+2.
REQ-027 SHALL produce an all-zero result, guard, round_bit and sticky when a left shift has shiftQtt >= W.

Reset
REQ-028 SHALL, while rst_n = 0, hold the FSM in IDLE and drive in_ready = 1, out_valid = 0 and result, guard, round_bit, sticky = 0.
REQ-029 SHALL, on rst_n assertion during SHIFT or DONE, abort and discard the in-flight transaction immediately, without waiting for clk.
REQ-030 SHALL accept a new request on the first rising edge after rst_n deasserts if in_valid = 1.

Verification
REQ-031 SHALL cover: W=23, STEP=4, num=0x700000, shiftQtt=6, dir=0 -> result=0x01C000, g/r/s=0/0/0, out_valid 3 clocks after accept.
REQ-032 SHALL cover: num=0x00000F, shiftQtt=2, dir=0 -> result=0x000003, g=1, r=1, s=0, out_valid 2 clocks after accept.
REQ-033 SHALL cover: num=0x00000F, shiftQtt=5, dir=0 -> result=0, g=0, r=1, s=1; and shiftQtt=0 -> result=0x00000F, g/r/s=0, out_valid 2 clocks after accept.
REQ-034 SHALL cover: num=0x400001, shiftQtt=200, dir=0 -> E=25, result=0, g=0, r=0, s=1, out_valid 8 clocks after accept.
REQ-035 SHALL cover: num=0x00000F, shiftQtt=21, dir=1 -> result=0x600000, g/r/s=0; and shiftQtt=30, dir=1 -> result=0.
REQ-036 SHALL cover: out_ready=0 for 5 clocks in DONE -> outputs stable, in_ready=0, a new in_valid is ignored; rst_n pulsed low mid-SHIFT -> out_valid=0 and outputs 0 at once, in_ready=1, next request processed correctly.
